// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and sizing for the ROM port arbiter and its byte sequencer.
package rom_port_arbiter_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 8 * WORD_BYTES;
    // Wide enough to hold a byte count of 0..WORD_BYTES inclusive
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } owner_t;

    // Transaction descriptor latched at grant time
    typedef struct packed {
        owner_t              owner;
        logic [ADDR_W-1:0]   base;
        logic [CNT_W-1:0]    len;
    } grant_t;

endpackage

// File: rtl/rom_byte_sequencer.sv
// Issues len byte reads at base, base+1, ... to a synchronous-read ROM and
// assembles the returned bytes little-endian into one word.
module rom_byte_sequencer
    import rom_port_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_base,
    input  logic [CNT_W-1:0]    i_len,
    output logic                o_mem_en,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic [7:0]          i_mem_rdata,
    output logic                o_done_c,
    output logic [DATA_W-1:0]   o_word_c
);

    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_k;
    logic [CNT_W-1:0]   r_c;
    logic               r_cap;
    logic [DATA_W-1:0]  r_asm;
    logic               r_mem_en;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  w_asm_next;

    // Issue side: byte 0 goes out on the start edge, the rest follow one per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_k        <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
        end else if (i_start) begin
            r_base     <= i_base;
            r_len      <= i_len;
            r_k        <= CNT_W'(1);
            r_mem_en   <= 1'b1;
            r_mem_addr <= i_base;
        end else if (r_k < r_len) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_base + ADDR_W'(r_k);
            r_k        <= r_k + CNT_W'(1);
        end else begin
            r_mem_en   <= 1'b0;
        end
    end

    // Merge the byte arriving this cycle into its lane of the assembly word
    always_comb begin
        w_asm_next = r_asm;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (CNT_W'(i) == r_c) begin
                w_asm_next[i*8 +: 8] = i_mem_rdata;
            end
        end
    end

    // Capture side: ROM data is valid the cycle after each issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= 1'b0;
            r_c   <= '0;
            r_asm <= '0;
        end else begin
            r_cap <= r_mem_en;
            if (i_start) begin
                r_c   <= '0;
                r_asm <= '0;
            end else if (r_cap) begin
                r_c   <= r_c + CNT_W'(1);
                r_asm <= w_asm_next;
            end
        end
    end

    assign o_mem_en   = r_mem_en;
    assign o_mem_addr = r_mem_addr;
    assign o_done_c   = r_cap && (r_c == (r_len - CNT_W'(1)));
    assign o_word_c   = w_asm_next;

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide ROM port between fetch and load.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ld_req,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic                ld_one_byte,
    output logic                ld_ack,
    output logic [DATA_W-1:0]   ld_rdata,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_rdata,
    output logic                busy
);

    state_t             r_state;
    state_t             w_state_next;
    owner_t             r_owner;
    owner_t             r_last_grant;
    grant_t             w_grant;
    logic               w_start;
    logic               w_tie;
    logic               w_seq_done_c;
    logic               w_done;
    logic [DATA_W-1:0]  w_seq_word_c;
    logic               r_if_ack;
    logic               r_ld_ack;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_ld_rdata;
    logic               r_busy;

    rom_byte_sequencer u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_base      (w_grant.base),
        .i_len       (w_grant.len),
        .o_mem_en    (mem_en),
        .o_mem_addr  (mem_addr),
        .i_mem_rdata (mem_rdata),
        .o_done_c    (w_seq_done_c),
        .o_word_c    (w_seq_word_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and grant decision; arbitration happens only in IDLE
    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_tie         = 1'b0;
        w_grant.owner = OWN_FETCH;
        w_grant.base  = if_addr;
        w_grant.len   = CNT_W'(WORD_BYTES);
        case (r_state)
            IDLE: begin
                if (if_req || ld_req) begin
                    w_start      = 1'b1;
                    w_state_next = READ;
                    if (if_req && ld_req) begin
                        w_tie         = 1'b1;
                        w_grant.owner = (r_last_grant == OWN_LOAD) ? OWN_FETCH : OWN_LOAD;
                    end else if (ld_req) begin
                        w_grant.owner = OWN_LOAD;
                    end
                    if (w_grant.owner == OWN_LOAD) begin
                        w_grant.base = ld_addr;
                        if (ld_one_byte) begin
                            w_grant.len = CNT_W'(1);
                        end
                    end
                end
            end
            READ: begin
                if (w_seq_done_c) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_done = w_seq_done_c && (r_state == READ);

    // Owner bookkeeping, ack pulses and per-requester data holding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWN_FETCH;
            r_last_grant <= OWN_LOAD;
            r_if_ack     <= 1'b0;
            r_ld_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_ld_rdata   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_busy   <= (w_state_next != IDLE);
            r_if_ack <= w_done && (r_owner == OWN_FETCH);
            r_ld_ack <= w_done && (r_owner == OWN_LOAD);
            if (w_start) begin
                r_owner <= w_grant.owner;
            end
            if (w_tie) begin
                r_last_grant <= w_grant.owner;
            end
            if (w_done && (r_owner == OWN_FETCH)) begin
                r_if_rdata <= w_seq_word_c;
            end
            if (w_done && (r_owner == OWN_LOAD)) begin
                r_ld_rdata <= w_seq_word_c;
            end
        end
    end

    assign if_ack   = r_if_ack;
    assign ld_ack   = r_ld_ack;
    assign if_rdata = r_if_rdata;
    assign ld_rdata = r_ld_rdata;
    assign busy     = r_busy;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios then randomized traffic,
// all checked against a transaction-level model of the arbiter.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ld_req, ld_one_byte;
    logic [7:0]  if_addr, ld_addr, mem_addr, mem_rdata;
    logic        if_ack, ld_ack, mem_en, busy;
    logic [31:0] if_rdata, ld_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: m_j counts cycles since grant (0 = idle); ack lands at len+2
    int          m_j;
    int          m_len;
    logic [7:0]  m_base;
    bit          m_owner;   // 0 fetch, 1 load
    bit          m_last;
    logic [31:0] m_if_rd, m_ld_rd;
    bit          e_if_ack, e_ld_ack;

    rom_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ack      (if_ack),
        .if_rdata    (if_rdata),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_one_byte (ld_one_byte),
        .ld_ack      (ld_ack),
        .ld_rdata    (ld_rdata),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ROM with memory[i] = i, one-cycle synchronous read
    always_ff @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_addr;
    end

    function automatic logic [31:0] rom_word(input logic [7:0] base, input int len);
        logic [31:0] w;
        logic [7:0]  a;
        w = 32'h0;
        for (int i = 0; i < len; i++) begin
            a = base + 8'(i);
            w[8*i +: 8] = a;
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_j = 0; m_len = 4; m_base = 8'h00; m_owner = 1'b0; m_last = 1'b1;
        m_if_rd = 32'h0; m_ld_rd = 32'h0;
    endtask

    // Advance the model by one cycle using the inputs present this cycle
    task automatic model_advance();
        if (m_j == 0) begin
            if (if_req || ld_req) begin
                if (if_req && ld_req) begin
                    m_owner = !m_last;
                    m_last  = m_owner;
                end else begin
                    m_owner = ld_req;
                end
                m_base = m_owner ? ld_addr : if_addr;
                m_len  = (m_owner && ld_one_byte) ? 1 : 4;
                m_j    = 1;
            end
        end else if (m_j == m_len + 2) begin
            m_j = 0;
        end else begin
            m_j++;
        end
    endtask

    task automatic check_outputs();
        bit         e_en;
        logic [7:0] e_addr;
        e_if_ack = (m_j != 0) && (m_j == m_len + 2) && !m_owner;
        e_ld_ack = (m_j != 0) && (m_j == m_len + 2) &&  m_owner;
        if (e_if_ack) m_if_rd = rom_word(m_base, m_len);
        if (e_ld_ack) m_ld_rd = rom_word(m_base, m_len);
        e_en   = (m_j >= 1) && (m_j <= m_len);
        e_addr = m_base + 8'(m_j - 1);
        chk("busy",     32'(busy),     32'(m_j != 0));
        chk("if_ack",   32'(if_ack),   32'(e_if_ack));
        chk("ld_ack",   32'(ld_ack),   32'(e_ld_ack));
        chk("if_rdata", if_rdata,      m_if_rd);
        chk("ld_rdata", ld_rdata,      m_ld_rd);
        chk("mem_en",   32'(mem_en),   32'(e_en));
        if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    endtask

    task automatic tick();
        model_advance();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int en_cnt;
        rst = 1'b1; if_req = 1'b0; ld_req = 1'b0; ld_one_byte = 1'b0;
        if_addr = 8'h00; ld_addr = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);

        // Word fetch at 0x10
        if_req = 1'b1; if_addr = 8'h10;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("wf_busy", 32'(busy), 32'h1);
            if (k <= 4) chk("wf_addr", 32'(mem_addr), 32'h10 + 32'(k - 1));
        end
        chk("wf_ack", 32'(if_ack), 32'h1);
        chk("wf_data", if_rdata, 32'h13121110);
        if_req = 1'b0; tick();

        // Byte load at 0x25
        ld_req = 1'b1; ld_addr = 8'h25; ld_one_byte = 1'b1;
        en_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            en_cnt += int'(mem_en);
        end
        chk("bl_ack", 32'(ld_ack), 32'h1);
        chk("bl_data", ld_rdata, 32'h00000025);
        chk("bl_en_cycles", 32'(en_cnt), 32'h1);
        ld_req = 1'b0; ld_one_byte = 1'b0; tick();

        // Address wrap
        if_req = 1'b1; if_addr = 8'hFE;
        ticks(6);
        chk("wrap_data", if_rdata, 32'h0100FFFE);
        if_req = 1'b0; tick();

        // Reset in the middle of a word fetch
        if_req = 1'b1; if_addr = 8'h10;
        ticks(3);
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_en", 32'(mem_en), 32'h0);
        chk("mid_rst_busy",   32'(busy),   32'h0);
        @(negedge clk);
        chk("mid_rst_no_ack", 32'(if_ack), 32'h0);
        rst = 1'b0;
        model_reset();
        check_outputs();
        ticks(6);
        chk("post_rst_ack", 32'(if_ack), 32'h1);
        chk("post_rst_data", if_rdata, 32'h13121110);
        if_req = 1'b0; tick();

        // Tie: fetch wins first
        if_req = 1'b1; if_addr = 8'h00; ld_req = 1'b1; ld_addr = 8'h40;
        ticks(6);
        chk("tie1_if_ack", 32'(if_ack), 32'h1);
        chk("tie1_if_data", if_rdata, 32'h03020100);
        if_req = 1'b0;
        ticks(7);
        chk("tie1_ld_ack", 32'(ld_ack), 32'h1);
        chk("tie1_ld_data", ld_rdata, 32'h43424140);
        ld_req = 1'b0; tick();

        // Repeated tie: load wins
        if_req = 1'b1; ld_req = 1'b1;
        ticks(6);
        chk("tie2_ld_ack", 32'(ld_ack), 32'h1);
        chk("tie2_if_idle", 32'(if_ack), 32'h0);
        ld_req = 1'b0;
        ticks(7);
        chk("tie2_if_ack", 32'(if_ack), 32'h1);
        if_req = 1'b0; tick();

        // Held load request runs twice, fetch raised meanwhile goes next
        ld_req = 1'b1; ld_addr = 8'h20;
        ticks(6);
        chk("held_ack1", 32'(ld_ack), 32'h1);
        ticks(3);
        if_req = 1'b1; if_addr = 8'h30;
        ticks(4);
        chk("held_ack2", 32'(ld_ack), 32'h1);
        chk("held_data", ld_rdata, 32'h23222120);
        ld_req = 1'b0;
        ticks(7);
        chk("held_if_ack", 32'(if_ack), 32'h1);
        chk("held_if_data", if_rdata, 32'h33323130);
        if_req = 1'b0; tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (e_if_ack) begin
                if ($urandom_range(0, 7) != 0) if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req  = 1'b1;
                if_addr = 8'($urandom);
            end
            if (e_ld_ack) begin
                if ($urandom_range(0, 7) != 0) ld_req = 1'b0;
            end else if (!ld_req && $urandom_range(0, 3) == 0) begin
                ld_req      = 1'b1;
                ld_addr     = 8'($urandom);
                ld_one_byte = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
Shares one byte-wide, synchronous-read program/data ROM port between two requesters: the instruction-fetch unit and the load unit.
Builds each 32-bit response by reading one byte per cycle, little-endian, at base, base+1, and so on. Byte loads read only one byte.
Sits between the core's fetch/LSU and the ROM. It replaces combinational multi-byte reads with a sequenced, arbitrated access.

Parameters:
ADDR_W, 8, byte address width; all address arithmetic wraps modulo 2^ADDR_W
WORD_BYTES, 4, bytes per full word; the response is 8*WORD_BYTES bits wide

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; level, held until if_ack
if_addr  in  ADDR_W  fetch byte address; stable while if_req is high
if_ack  out  1  one-cycle pulse; if_rdata is valid in this cycle
if_rdata  out  32  fetched word
ld_req  in  1  load request; level, held until ld_ack
ld_addr  in  ADDR_W  load byte address; stable while ld_req is high
ld_one_byte  in  1  1 = single-byte load; 0 = full word; stable while ld_req is high
ld_ack  out  1  one-cycle pulse; ld_rdata is valid in this cycle
ld_rdata  out  32  loaded data; upper 24 bits are zero for byte loads
mem_en  out  1  ROM read enable
mem_addr  out  ADDR_W  ROM byte address
mem_rdata  in  8  ROM data; valid the cycle after mem_en/mem_addr are sampled
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: the reset state is IDLE. All of the following are 0: if_ack, ld_ack, mem_en, mem_addr, if_rdata, ld_rdata, the byte counters and the assembly register. last_grant resets to LOAD, so the first tie goes to fetch.
- Reset mid-transaction: the transaction is dropped and no ack is issued. A requester that is still holding req is re-arbitrated starting from IDLE.
- States are IDLE, READ and RESP.
- IDLE, no request: stays in IDLE.
- IDLE, one request: grants it and latches base address, owner and length. Length is 1 for a byte load, otherwise WORD_BYTES. Moves to READ.
- IDLE, both requests (tie): grants the requester other than last_grant, then updates last_grant. This is round-robin.
- READ, issue side: issue counter k runs 0..len-1. Each cycle drives mem_en=1 and mem_addr=base+k (wraps). mem_en=0 once k reaches len.
- READ, capture side: capture counter c. Byte c is taken from mem_rdata in the cycle after its issue and written to lane c of the assembly register. Lanes not written stay 0.
- READ lasts len+1 cycles, then moves to RESP.
- RESP: lasts one cycle. Pulses ack to the owner with rdata equal to the assembly register. Returns to IDLE.
- Latency, counted from a request first seen in an IDLE cycle T: word ack at T+6, byte ack at T+3.
- The non-owner's ack stays 0 throughout. Its rdata holds its last delivered value.
- Requester protocol: deassert req in the cycle after ack, unless another access is wanted.
- Req still high in the IDLE cycle after RESP: starts a new transaction. Back-to-back word throughput is 1 word per 7 cycles.
- Req withdrawn during READ: this is a protocol violation. The transaction completes and the ack still pulses.
- Fetch is always full-word. ld_one_byte is sampled only at grant.

Decomposition:
- Shared package holds the state enum (IDLE/READ/RESP), owner IDs (OWN_FETCH, OWN_LOAD), WORD_BYTES and ADDR_W.
- One natural sub-module, rom_byte_sequencer, contains the issue/capture counters, address generation and lane assembly. It is driven by start, base and len, and returns done and word.
- The top level holds arbitration, last_grant and ack/rdata routing.

Test Plan:
All scenarios use a ROM preloaded with memory[i]=i.
- Word fetch: if_req=1, if_addr=0x10 at cycle 0 -> mem_addr sequence 10,11,12,13 in cycles 1-4; if_ack=1 at cycle 6 with if_rdata=0x13121110; busy high in cycles 1-6.
- Byte load: ld_req=1, ld_addr=0x25, ld_one_byte=1 -> exactly one mem_en cycle; ld_ack at cycle 3 with ld_rdata=0x00000025.
- Tie after reset: both req at cycle 0 (if 0x00, ld 0x40 word) -> if_ack at cycle 6 with 0x03020100; ld_ack at cycle 13 with 0x43424140. Repeat the tie -> load is served first.
- Wrap: word fetch at 0xFE -> mem_addr FE,FF,00,01; if_rdata=0x0100FFFE.
- Reset mid-op: word fetch starts at cycle 0, rst pulses in cycle 3 -> mem_en=0 and no ack. After release, with req still held -> a clean new transaction delivers 0x13121110 (addr 0x10).
- Held req: ld_req kept high across ld_ack -> a second identical transaction runs and acks 7 cycles after the first; if_req, raised during it, is granted next.
